// File: rtl/draw_request_issuer_pkg.sv
//==============================================================================
// Module   : draw_request_issuer_pkg
// Brief    : Shared constants for the block-draw request issuer: FSM encoding,
//            default field widths and the drawer's full-screen clear duration.
// Revision : 1.0
//==============================================================================
`default_nettype none

package draw_request_issuer_pkg;

    localparam int c_default_x_w   = 8;
    localparam int c_default_y_w   = 7;
    localparam int c_default_col_w = 3;

    // Drawer full-screen clear time; any watchdog limit must sit above this.
    localparam int c_clear_cycles  = 33800;

    localparam int c_state_w = 3;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle        = 3'd0;
    localparam state_t c_st_issue_clear = 3'd1;
    localparam state_t c_st_issue_draw  = 3'd2;
    localparam state_t c_st_wait_ack    = 3'd3;
    localparam state_t c_st_wait_done   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/draw_request_issuer_fifo.sv
//==============================================================================
// Module   : draw_req_fifo
// Brief    : Synchronous request FIFO with flush; a push on the flush edge is
//            kept as the sole entry and a pop on the flush edge is dropped.
// Revision : 1.0
//==============================================================================
`default_nettype none

module draw_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            // Head jumps to the write slot, so a same-edge push becomes the only entry.
            r_rd_ptr <= r_wr_ptr;
            r_wr_ptr <= w_push_ok ? r_wr_ptr + c_ptr_w'(1) : r_wr_ptr;
            r_count  <= c_cnt_w'(w_push_ok);
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_request_issuer.sv
//==============================================================================
// Module   : draw_request_issuer
// Brief    : Queues block-draw and screen-clear requests and issues them as
//            single-cycle pulses to the 4x4 block drawer when it is ready.
//            Optional watchdog: define DRAW_ISSUER_WATCHDOG_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module draw_request_issuer
    import draw_request_issuer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int X_W         = c_default_x_w,
    parameter int Y_W         = c_default_y_w,
    parameter int COL_W       = c_default_col_w,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [X_W-1:0]           req_x,
    input  logic [Y_W-1:0]           req_y,
    input  logic [COL_W-1:0]         req_colour,
    input  logic                     clear_req,
    input  logic                     ready_to_draw,
    output logic                     enable_start,
    output logic                     enable_clear,
    output logic [X_W-1:0]           x_out,
    output logic [Y_W-1:0]           y_out,
    output logic [COL_W-1:0]         colour_out,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef DRAW_ISSUER_WATCHDOG_EN
   ,output logic                     wdog_err
`endif
);

    localparam int c_pld_w = X_W + Y_W + COL_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("DEPTH must be a power of 2 and at least 2");
    end

    if (WDOG_CYCLES <= c_clear_cycles) begin : g_wdog_limit_chk
        $error("WDOG_CYCLES must exceed the drawer full-clear duration");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic               r_clear_pending;
    logic               r_enable_start;
    logic               r_enable_clear;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic [COL_W-1:0]   r_colour;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_pld_w-1:0] w_head;
    logic               w_pop;
    logic               w_issue_clear;
    logic               w_waiting;
    logic               w_wdog_hit;

    draw_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_pld_w)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (clear_req),
        .push   (req_valid),
        .pop    (w_pop),
        .wdata  ({req_x, req_y, req_colour}),
        .rdata  (w_head),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty),
        .count  (fifo_count)
    );

`ifdef DRAW_ISSUER_WATCHDOG_EN
    logic [15:0] r_wdog_cnt;
    logic        r_wdog_err;

    assign w_wdog_hit = w_waiting && (r_wdog_cnt == 16'(WDOG_CYCLES));
    assign wdog_err   = r_wdog_err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= (w_waiting && !w_wdog_hit) ? r_wdog_cnt + 16'd1 : 16'd0;
            if (w_wdog_hit) begin
                r_wdog_err <= 1'b1;
            end
        end
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (ready_to_draw && r_clear_pending) begin
                    w_next_state = c_st_issue_clear;
                end else if (w_pop) begin
                    w_next_state = c_st_issue_draw;
                end
            end
            c_st_issue_clear: w_next_state = c_st_wait_ack;
            c_st_issue_draw:  w_next_state = c_st_wait_ack;
            c_st_wait_ack: begin
                if (w_wdog_hit) begin
                    w_next_state = c_st_idle;
                end else if (!ready_to_draw) begin
                    w_next_state = c_st_wait_done;
                end
            end
            c_st_wait_done: begin
                if (w_wdog_hit || ready_to_draw) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // A clear arriving on the pop edge wins: the draw is not started and the flush takes the entry.
    always_comb begin
        w_pop         = 1'b0;
        w_issue_clear = 1'b0;
        w_waiting     = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_pop = ready_to_draw && !r_clear_pending && !w_fifo_empty && !clear_req;
            end
            c_st_issue_clear: w_issue_clear = 1'b1;
            c_st_wait_ack,
            c_st_wait_done:   w_waiting = 1'b1;
            default: begin
                w_pop         = 1'b0;
                w_issue_clear = 1'b0;
                w_waiting     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_enable_start  <= 1'b0;
            r_enable_clear  <= 1'b0;
            r_clear_pending <= 1'b0;
            r_x             <= '0;
            r_y             <= '0;
            r_colour        <= '0;
        end else begin
            r_enable_start <= (r_state == c_st_issue_draw);
            r_enable_clear <= w_issue_clear;
            if (clear_req) begin
                r_clear_pending <= 1'b1;
            end else if (w_issue_clear) begin
                r_clear_pending <= 1'b0;
            end
            if (w_pop) begin
                {r_x, r_y, r_colour} <= w_head;
            end
        end
    end

    assign req_ready    = !w_fifo_full;
    assign enable_start = r_enable_start;
    assign enable_clear = r_enable_clear;
    assign x_out        = r_x;
    assign y_out        = r_y;
    assign colour_out   = r_colour;
    assign busy         = (r_state != c_st_idle) || !w_fifo_empty || r_clear_pending;

endmodule

`default_nettype wire

// File: doc/draw_request_issuer.md
Name: draw_request_issuer

Overview:
- Initiator side of the block-draw handshake. Queues block-draw requests (x, y, colour) from game/sequence logic in a small FIFO and accepts screen-clear requests.
- Issues single-cycle enable_start / enable_clear pulses to the 4x4 block drawer, only when that drawer reports ready_to_draw.
- Holds the coordinate and colour outputs stable until the drawer has loaded them.

Parameters:
- DEPTH, 8, request FIFO depth; must be a power of 2, at least 2.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- COL_W, 3, colour width.
- WDOG_CYCLES, 65535, watchdog limit in cycles; only used with WATCHDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  draw request present.
- req_ready  out  1  FIFO can accept a request (high when not full).
- req_x  in  X_W  block x.
- req_y  in  Y_W  block y.
- req_colour  in  COL_W  block colour.
- clear_req  in  1  one-cycle pulse requesting a full-screen clear.
- ready_to_draw  in  1  drawer is idle and can accept a start.
- enable_start  out  1  one-cycle pulse: draw block at x_out/y_out.
- enable_clear  out  1  one-cycle pulse: clear screen.
- x_out  out  X_W  registered x presented to drawer.
- y_out  out  Y_W  registered y presented to drawer.
- colour_out  out  COL_W  registered colour presented to drawer.
- busy  out  1  FSM not in IDLE, or FIFO non-empty, or clear pending.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, resetn=0): all outputs 0 except req_ready=1; FIFO empty; clear_pending=0; FSM in IDLE. Reset mid-draw discards every queued request and any pending clear.
- Push: request accepted on an edge where req_valid && req_ready. A push while full is ignored and is not counted.
- clear_req latches clear_pending=1 and flushes the FIFO on the same edge.
  - A push on that same edge is kept and becomes the only entry.
  - A pop on that same edge is overridden by the flush.
- FSM states: IDLE, ISSUE_CLEAR, ISSUE_DRAW, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If ready_to_draw && clear_pending, go to ISSUE_CLEAR. Clear has priority over draw.
  - Else if ready_to_draw && FIFO non-empty: pop the head into x_out/y_out/colour_out, go to ISSUE_DRAW.
  - Else stay in IDLE.
- ISSUE_CLEAR: enable_clear=1 for exactly this cycle; clear_pending cleared; go to WAIT_ACK.
- ISSUE_DRAW: enable_start=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for ready_to_draw=0 (drawer has left its wait state), then go to WAIT_DONE.
- WAIT_DONE: wait for ready_to_draw=1, then go to IDLE.
- Output stability: x_out/y_out/colour_out are written only on the IDLE pop. They are held through ISSUE_DRAW, WAIT_ACK and WAIT_DONE, which covers the drawer's load cycle.
- enable_start/enable_clear are registered, never both high, and never high on consecutive cycles.
- Latency: request pushed on edge k into an empty FIFO with FSM idle and ready_to_draw=1.
  - Pop occurs on edge k+1.
  - enable_start is high between edges k+2 and k+3.
- A clear_req arriving while a draw is in flight is queued. It is issued after WAIT_DONE returns to IDLE; the in-flight draw completes.
- Pointers wrap modulo DEPTH. fifo_count is exact for simultaneous push and pop (count unchanged).

Optional Feature:
- Macro: DRAW_ISSUER_WATCHDOG_EN.
- With the macro defined:
  - Adds output wdog_err (1 bit, reset 0) and a 16-bit counter that runs in WAIT_ACK/WAIT_DONE.
  - When the counter reaches WDOG_CYCLES, wdog_err is set (sticky until reset) and the FSM returns to IDLE.
  - WDOG_CYCLES must exceed the drawer's full-clear duration (about 33.8k cycles).
- Without the macro: no port, no counter; the FSM waits indefinitely.

Decomposition:
- Shared package: FSM state encoding constants, default X_W/Y_W/COL_W, and the screen-clear duration constant used to bound WDOG_CYCLES.
- One sub-module, draw_req_fifo: synchronous FIFO with flush input, push/pop, full/empty and count. The issuer FSM stays in the top module.

Test Plan:
- Single request: push (x=10, y=20, col=3), ready_to_draw=1 -> enable_start high one cycle exactly 2 edges after push. x_out/y_out/colour_out equal 10/20/3 and stay stable until ready_to_draw returns high.
- Back-to-back: push 3 requests; model drawer holds ready low for 17 cycles per draw -> three enable_start pulses in push order, each issued only after ready re-rises; fifo_count steps 3,2,1,0.
- Full: push DEPTH+2 requests with ready_to_draw=0 -> req_ready=0 after DEPTH pushes, fifo_count=DEPTH, extra pushes dropped.
- Clear priority/flush: 4 queued, clear_req with a simultaneous push of (5,5,1) -> fifo_count=1, enable_clear issued before the enable_start for (5,5,1).
- Clear during draw: clear_req while in WAIT_DONE -> no enable_clear until ready_to_draw=1; then enable_clear on the following issue cycle.
- Reset mid-operation: resetn low during WAIT_ACK with 2 queued -> all outputs 0, req_ready=1, fifo_count=0; no pulses after release until a new request arrives.
